// File: rtl/branch_resolve_unit_if.sv
// Bundle between fetch/execute and the branch resolve unit.
//   Pred_*          : prediction record issued at fetch (Pred_ready back-pressure)
//   Res_*           : outcome of the oldest in-flight branch from execute
//   Branch_resolved : training outcome to the predictor
//   Branch_addr_IN  : training PC (0 = no update)
//   FLUSH           : mispredict flush pulse
//   Redirect_addr   : correct next-fetch PC while FLUSH=1
//   Branch_count    : resolved-branch performance counter
//   Mispred_count   : mispredict performance counter
//   Error           : sticky protocol error flag
// The master modport is the pipeline side; the slave modport is the resolve unit.
interface branch_resolve_unit_if;
    logic        Pred_valid;
    logic [31:0] Pred_addr;
    logic        Pred_taken;
    logic [31:0] Pred_target;
    logic        Pred_ready;
    logic        Res_valid;
    logic [31:0] Res_addr;
    logic        Res_taken;
    logic [31:0] Res_target;
    logic        Branch_resolved;
    logic [31:0] Branch_addr_IN;
    logic        FLUSH;
    logic [31:0] Redirect_addr;
    logic [31:0] Branch_count;
    logic [31:0] Mispred_count;
    logic        Error;

    modport master (
        output Pred_valid, Pred_addr, Pred_taken, Pred_target,
        output Res_valid, Res_addr, Res_taken, Res_target,
        input  Pred_ready, Branch_resolved, Branch_addr_IN, FLUSH,
        input  Redirect_addr, Branch_count, Mispred_count, Error
    );

    modport slave (
        input  Pred_valid, Pred_addr, Pred_taken, Pred_target,
        input  Res_valid, Res_addr, Res_taken, Res_target,
        output Pred_ready, Branch_resolved, Branch_addr_IN, FLUSH,
        output Redirect_addr, Branch_count, Mispred_count, Error
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: update-side partner of the local branch predictor.
// Records each fetch prediction in an in-order tracking FIFO, pairs it with
// the outcome resolved in execute, trains the predictor, and raises a
// one-cycle FLUSH with a redirect PC on mispredict.
// Ports:
//   CLK   : clock, all state updates on posedge
//   RESET : asynchronous, active-high reset
//   bus   : branch_resolve_unit_if.slave (prediction push, resolve,
//           training/flush outputs, performance counters, Error)
module branch_resolve_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic                 CLK,
    input  logic                 RESET,
    branch_resolve_unit_if.slave bus
);

    logic [31:0]      addr_mem   [DEPTH];
    logic [31:0]      target_mem [DEPTH];
    logic [DEPTH-1:0] taken_mem;

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;

    logic        resolved_q;
    logic [31:0] train_addr_q;
    logic        flush_q;
    logic [31:0] redirect_q;
    logic [31:0] branch_cnt_q;
    logic [31:0] mispred_cnt_q;
    logic        error_q;

    logic        full, empty;
    logic        res_accept, pop, push, mispredict;
    logic        underflow, overflow, addr_mismatch;
    logic [31:0] head_addr, head_target;
    logic        head_taken;
    logic [31:0] redirect_next;

    always_comb begin
        full          = (count == (PTR_W+1)'(DEPTH));
        empty         = (count == '0);
        head_addr     = addr_mem[rd_ptr];
        head_target   = target_mem[rd_ptr];
        head_taken    = taken_mem[rd_ptr];
        // A resolve presented during the flush cycle belongs to the squashed path.
        res_accept    = bus.Res_valid & ~flush_q;
        pop           = res_accept & ~empty;
        underflow     = res_accept & empty;
        mispredict    = pop & ((head_taken != bus.Res_taken) |
                               (bus.Res_taken & (head_target != bus.Res_target)));
        addr_mismatch = pop & (head_addr != bus.Res_addr);
        overflow      = bus.Pred_valid & full;
        // Pred_ready is based on the current count only; a same-cycle pop does not free a slot.
        push          = bus.Pred_valid & ~full & ~mispredict;
        redirect_next = bus.Res_taken ? bus.Res_target : bus.Res_addr + 32'd8;
    end

    // Storage needs no reset: entries are only ever read behind a valid count.
    always_ff @(posedge CLK) begin
        if (push) begin
            addr_mem[wr_ptr]   <= bus.Pred_addr;
            target_mem[wr_ptr] <= bus.Pred_target;
            taken_mem[wr_ptr]  <= bus.Pred_taken;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (mispredict) begin
            // Everything younger than the mispredicted branch is wrong path.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            resolved_q    <= 1'b0;
            train_addr_q  <= '0;
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
            error_q       <= 1'b0;
        end else begin
            resolved_q   <= pop & bus.Res_taken;
            train_addr_q <= pop ? bus.Res_addr : '0;
            flush_q      <= mispredict;
            if (mispredict) redirect_q <= redirect_next;
            if (pop && branch_cnt_q != '1)        branch_cnt_q  <= branch_cnt_q + 32'd1;
            if (mispredict && mispred_cnt_q != '1) mispred_cnt_q <= mispred_cnt_q + 32'd1;
            if (underflow | overflow | addr_mismatch) error_q <= 1'b1;
        end
    end

    assign bus.Pred_ready      = ~full;
    assign bus.Branch_resolved = resolved_q;
    assign bus.Branch_addr_IN  = train_addr_q;
    assign bus.FLUSH           = flush_q;
    assign bus.Redirect_addr   = redirect_q;
    assign bus.Branch_count    = branch_cnt_q;
    assign bus.Mispred_count   = mispred_cnt_q;
    assign bus.Error           = error_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model.
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        bit          taken;
        logic [31:0] target;
    } entry_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    branch_resolve_unit_if bus();

    branch_resolve_unit #(.DEPTH(4), .PTR_W(2)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    entry_t      q[$];
    bit          m_res, m_flush, m_err;
    logic [31:0] m_addr, m_redir, m_bcnt, m_mcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("ready",    32'(bus.Pred_ready),      32'(q.size() < DEPTH));
        check("resolved", 32'(bus.Branch_resolved), 32'(m_res));
        check("train",    bus.Branch_addr_IN,       m_addr);
        check("flush",    32'(bus.FLUSH),           32'(m_flush));
        check("redirect", bus.Redirect_addr,        m_redir);
        check("bcnt",     bus.Branch_count,         m_bcnt);
        check("mcnt",     bus.Mispred_count,        m_mcnt);
        check("error",    32'(bus.Error),           32'(m_err));
    endtask

    task automatic model_reset();
        q.delete();
        m_res = 0; m_flush = 0; m_err = 0;
        m_addr = '0; m_redir = '0; m_bcnt = '0; m_mcnt = '0;
    endtask

    task automatic model_step(input bit pv, input logic [31:0] pa, input bit pt, input logic [31:0] ptg,
                              input bit rv, input logic [31:0] ra, input bit rt, input logic [31:0] rtg);
        bit full, acc, pop, mis;
        entry_t h;
        full = (q.size() == DEPTH);
        acc  = rv && !m_flush;
        pop  = acc && (q.size() > 0);
        mis  = 0;
        if (acc && q.size() == 0) m_err = 1;
        if (pv && full) m_err = 1;
        if (pop) begin
            h = q.pop_front();
            if (h.addr != ra) m_err = 1;
            mis = (h.taken != rt) || (rt && h.target != rtg);
        end
        if (mis) q.delete();
        else if (pv && !full) q.push_back('{pa, pt, ptg});
        m_addr  = pop ? ra : 32'd0;
        m_res   = pop && rt;
        m_flush = mis;
        if (mis) m_redir = rt ? rtg : ra + 32'd8;
        if (pop && m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
        if (mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
    endtask

    // Called at a negedge: checks the outputs of the previous edge, drives
    // this cycle's inputs, advances the model, and returns at the next negedge.
    task automatic cyc(input bit pv, input logic [31:0] pa, input bit pt, input logic [31:0] ptg,
                       input bit rv, input logic [31:0] ra, input bit rt, input logic [31:0] rtg);
        compare_all();
        bus.Pred_valid = pv; bus.Pred_addr = pa; bus.Pred_taken = pt; bus.Pred_target = ptg;
        bus.Res_valid  = rv; bus.Res_addr  = ra; bus.Res_taken  = rt; bus.Res_target  = rtg;
        model_step(pv, pa, pt, ptg, rv, ra, rt, rtg);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        cyc(0, '0, 0, '0, 0, '0, 0, '0);
    endtask

    task automatic clear_inputs();
        bus.Pred_valid = 0; bus.Pred_addr = '0; bus.Pred_taken = 0; bus.Pred_target = '0;
        bus.Res_valid  = 0; bus.Res_addr  = '0; bus.Res_taken  = 0; bus.Res_target  = '0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        clear_inputs();
        #1;
        model_reset();
        compare_all();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        @(negedge CLK);
        do_reset();

        // 1: reset in the middle of traffic discards in-flight entries
        cyc(1, 32'h0040_0500, 1, 32'h0040_0600, 0, '0, 0, '0);
        cyc(1, 32'h0040_0504, 0, 32'h0, 1, 32'h0040_0500, 1, 32'h0040_0600);
        do_reset();
        check("t1_ready", 32'(bus.Pred_ready), 32'd1);
        check("t1_bcnt",  bus.Branch_count, 32'd0);

        // 2: correctly predicted taken branch
        cyc(1, 32'h0040_0100, 1, 32'h0040_0200, 0, '0, 0, '0);
        cyc(0, '0, 0, '0, 1, 32'h0040_0100, 1, 32'h0040_0200);
        check("t2_train", bus.Branch_addr_IN, 32'h0040_0100);
        check("t2_res",   32'(bus.Branch_resolved), 32'd1);
        check("t2_flush", 32'(bus.FLUSH), 32'd0);
        check("t2_bcnt",  bus.Branch_count, 32'd1);
        idle();
        do_reset();

        // 3: predicted NT, actually taken; younger and same-cycle pushes are squashed
        cyc(1, 32'h0040_0100, 0, 32'h0, 0, '0, 0, '0);
        cyc(1, 32'h0040_0110, 0, 32'h0, 0, '0, 0, '0);
        cyc(1, 32'h0040_0120, 0, 32'h0, 1, 32'h0040_0100, 1, 32'h0040_0300);
        check("t3_flush", 32'(bus.FLUSH), 32'd1);
        check("t3_redir", bus.Redirect_addr, 32'h0040_0300);
        check("t3_mcnt",  bus.Mispred_count, 32'd1);
        // Resolve during the flush cycle is ignored
        cyc(0, '0, 0, '0, 1, 32'h0040_0110, 0, '0);
        check("t3_ign", bus.Branch_addr_IN, 32'd0);
        check("t3_err", 32'(bus.Error), 32'd0);
        // FIFO now empty: a push and its resolve must pair directly
        cyc(1, 32'h0040_0140, 0, 32'h0, 0, '0, 0, '0);
        cyc(0, '0, 0, '0, 1, 32'h0040_0140, 0, '0);
        check("t3_empty", 32'(bus.Error), 32'd0);
        idle();
        do_reset();

        // 4: predicted taken, actually not taken -> redirect past delay slot
        cyc(1, 32'h0040_0100, 1, 32'h0040_0200, 0, '0, 0, '0);
        cyc(0, '0, 0, '0, 1, 32'h0040_0100, 0, 32'h0040_0200);
        check("t4_flush", 32'(bus.FLUSH), 32'd1);
        check("t4_redir", bus.Redirect_addr, 32'h0040_0108);
        idle();
        check("t4_hold",  bus.Redirect_addr, 32'h0040_0108);
        do_reset();

        // 5: overflow then in-order drain, then wrap rounds
        for (int i = 0; i < 5; i++) begin
            cyc(1, 32'h0040_0200 + 32'(4*i), 1, 32'h0050_0000 + 32'(i), 0, '0, 0, '0);
            if (i == 3) check("t5_full", 32'(bus.Pred_ready), 32'd0);
        end
        check("t5_err", 32'(bus.Error), 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(0, '0, 0, '0, 1, 32'h0040_0200 + 32'(4*i), 1, 32'h0050_0000 + 32'(i));
            check("t5_order", bus.Branch_addr_IN, 32'h0040_0200 + 32'(4*i));
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h0040_0300 + 32'(4*i), 0, 32'h0, 0, '0, 0, '0);
            cyc(0, '0, 0, '0, 1, 32'h0040_0300 + 32'(4*i), 0, '0);
            check("t5_wrap", bus.Branch_addr_IN, 32'h0040_0300 + 32'(4*i));
        end
        idle();
        do_reset();

        // 6: resolve with an empty FIFO
        cyc(0, '0, 0, '0, 1, 32'h0040_0100, 1, 32'h0040_0200);
        check("t6_err",   32'(bus.Error), 32'd1);
        check("t6_train", bus.Branch_addr_IN, 32'd0);
        check("t6_bcnt",  bus.Branch_count, 32'd0);
        idle();
        do_reset();

        // Randomized traffic, with one reset partway through
        for (int n = 0; n < 600; n++) begin
            bit pv, pt, rv, rt;
            logic [31:0] pa, ptg, ra, rtg;
            if (n == 300) do_reset();
            pv  = ($urandom_range(0, 99) < 55);
            pa  = $urandom & 32'hFFFF_FFFC;
            pt  = $urandom_range(0, 1) == 1;
            ptg = $urandom & 32'hFFFF_FFFC;
            rv  = ($urandom_range(0, 99) < 45);
            ra  = $urandom & 32'hFFFF_FFFC;
            rt  = $urandom_range(0, 1) == 1;
            rtg = $urandom & 32'hFFFF_FFFC;
            if (q.size() > 0) begin
                if ($urandom_range(0, 99) < 95) ra  = q[0].addr;
                if ($urandom_range(0, 99) < 80) rt  = q[0].taken;
                if ($urandom_range(0, 99) < 85) rtg = q[0].target;
            end
            cyc(pv, pa, pt, ptg, rv, ra, rt, rtg);
        end
        compare_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
